// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between four byte requesters.
// Handles the UART valid/busy handshake and abandons an attempt if busy never rises.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_x4,
  input  logic       rst_x,
  input  logic [3:0] i_req_valid,
  input  logic [7:0] i_req_data_0,
  input  logic [7:0] i_req_data_1,
  input  logic [7:0] i_req_data_2,
  input  logic [7:0] i_req_data_3,
  output logic [3:0] o_req_ack,
  output logic [3:0] o_grant,
  output logic [7:0] o_uart_data,
  output logic       o_uart_valid,
  input  logic       i_uart_busy,
  output logic       o_timeout
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ISSUE = 2'd1;
  localparam logic [1:0]  ST_SEND  = 2'd2;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_dly_q;
  logic [3:0]  grant_q, grant_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [3:0]  ack_q, ack_d;
  logic        timeout_q, timeout_d;

  logic        busy_rise;
  logic        busy_fall;
  logic        win_hit;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [7:0]  win_data;

  assign busy_rise = ~busy_dly_q & i_uart_busy;
  assign busy_fall = busy_dly_q & ~i_uart_busy;

  // Round-robin search starting at the pointer; first set request wins.
  always_comb begin
    win_hit = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_hit && i_req_valid[cand]) begin
        win_hit = 1'b1;
        win_idx = cand;
      end else begin
        win_hit = win_hit;
      end
    end
    case (win_idx)
      2'd0:    win_data = i_req_data_0;
      2'd1:    win_data = i_req_data_1;
      2'd2:    win_data = i_req_data_2;
      2'd3:    win_data = i_req_data_3;
      default: win_data = 8'h00;
    endcase
  end

  // Next-state logic for the grant / issue / send sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ack_d     = 4'b0000;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (win_hit && !i_uart_busy) begin
          grant_d = 4'b0001 << win_idx;
          data_d  = win_data;
          valid_d = 1'b1;
          cnt_d   = 16'd0;
          ptr_d   = win_idx + 2'd1;
          state_d = ST_ISSUE;
        end else begin
          grant_d = 4'b0000;
        end
      end
      ST_ISSUE: begin
        // A busy rise on the last allowed cycle still counts as accepted.
        if (busy_rise) begin
          valid_d = 1'b0;
          ack_d   = grant_q;
          state_d = ST_SEND;
        end else if (cnt_q == CNT_LAST) begin
          valid_d   = 1'b0;
          grant_d   = 4'b0000;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SEND: begin
        if (busy_fall) begin
          grant_d = 4'b0000;
          state_d = ST_IDLE;
        end else begin
          grant_d = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_x4 or negedge rst_x) begin
    if (!rst_x) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      cnt_q      <= 16'd0;
      busy_dly_q <= 1'b0;
      grant_q    <= 4'b0000;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ack_q      <= 4'b0000;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      busy_dly_q <= i_uart_busy;
      grant_q    <= grant_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_req_ack    = ack_q;
  assign o_grant      = grant_q;
  assign o_uart_data  = data_q;
  assign o_uart_valid = valid_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a driver plays requesters and the UART,
// a reference model predicts each transfer, and a monitor checks every valid pulse against it.
module tb_uart_tx_arbiter;
  localparam int T = 8;
  localparam int N = 40;

  logic       clk_x4 = 1'b0;
  logic       rst_x = 1'b0;
  logic [3:0] req_valid = 4'b0000;
  logic [7:0] data_arr [4];
  logic       uart_busy = 1'b0;
  logic [3:0] o_req_ack;
  logic [3:0] o_grant;
  logic [7:0] o_uart_data;
  logic       o_uart_valid;
  logic       o_timeout;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_x4      (clk_x4),
    .rst_x       (rst_x),
    .i_req_valid (req_valid),
    .i_req_data_0(data_arr[0]),
    .i_req_data_1(data_arr[1]),
    .i_req_data_2(data_arr[2]),
    .i_req_data_3(data_arr[3]),
    .o_req_ack   (o_req_ack),
    .o_grant     (o_grant),
    .o_uart_data (o_uart_data),
    .o_uart_valid(o_uart_valid),
    .i_uart_busy (uart_busy),
    .o_timeout   (o_timeout)
  );

  always #5 clk_x4 = ~clk_x4;

  typedef struct {
    int         k;
    logic [7:0] data;
    bit         timeout;
    int         d;
    int         len;
  } txn_t;

  txn_t sb_q[$];
  int   tot = 0;
  int   bad = 0;
  int   ptr_m = 0;
  bit   exp_sticky = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pick the first requesting index at or after the pointer.
  function automatic txn_t plan(input logic [3:0] vec, input bit allow_to, input int dfix);
    txn_t t;
    t.k = 0;
    for (int i = 0; i < 4; i++) begin
      if (vec[(ptr_m + i) % 4]) begin
        t.k = (ptr_m + i) % 4;
        break;
      end
    end
    ptr_m     = (t.k + 1) % 4;
    t.data    = data_arr[t.k];
    t.timeout = allow_to && ($urandom_range(0, 4) == 0);
    t.d       = (dfix >= 0) ? dfix : (($urandom_range(0, 3) == 0) ? T - 1 : int'($urandom_range(0, T - 1)));
    t.len     = t.timeout ? T : t.d + 1;
    return t;
  endfunction

  task automatic wait_valid(output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_x4); #1;
      if (o_uart_valid) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic handshake(input txn_t t);
    int  h;
    bit  fell;
    if (!t.timeout) begin
      repeat (t.d) begin @(posedge clk_x4); #1; end
      uart_busy = 1'b1;
      h = $urandom_range(1, 4);
      repeat (h) begin @(posedge clk_x4); #1; end
      uart_busy = 1'b0;
    end else begin
      fell = 1'b0;
      for (int c = 0; c < T + 5; c++) begin
        @(posedge clk_x4); #1;
        if (!o_uart_valid) begin
          fell = 1'b1;
          break;
        end
      end
      if (!fell) check("timeout_valid_fall", 32'd0, 32'd1);
    end
  endtask

  // Monitor: capture each valid pulse and compare it with the next predicted transfer.
  initial begin
    txn_t       e;
    logic [3:0] g_seen = 4'b0000;
    logic [7:0] d_seen = 8'h00;
    int         len = 0;
    bit         prev_v = 1'b0;
    bit         ack_chk = 1'b0;
    forever begin
      @(posedge clk_x4); #1;
      if (!rst_x) begin
        prev_v  = 1'b0;
        ack_chk = 1'b0;
        continue;
      end
      if (ack_chk) begin
        check("ack_one_cycle", 32'(o_req_ack), 32'd0);
        ack_chk = 1'b0;
      end
      if (o_uart_valid && !prev_v) begin
        g_seen = o_grant;
        d_seen = o_uart_data;
        len    = 1;
      end else if (o_uart_valid) begin
        len++;
      end
      if (!o_uart_valid && prev_v) begin
        if (sb_q.size() == 0) begin
          check("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("grant_owner", 32'(g_seen), 32'd1 << e.k);
          check("uart_data", 32'(d_seen), 32'(e.data));
          check("valid_len", 32'(len), 32'(e.len));
          check("ack", 32'(o_req_ack), e.timeout ? 32'd0 : (32'd1 << e.k));
          check("grant_after", 32'(o_grant), e.timeout ? 32'd0 : (32'd1 << e.k));
          check("data_hold", 32'(o_uart_data), 32'(e.data));
          if (e.timeout) exp_sticky = 1'b1;
          check("timeout_flag", 32'(o_timeout), 32'(exp_sticky));
          ack_chk = !e.timeout;
        end
      end
      prev_v = o_uart_valid;
    end
  end

  // Driver: requesters plus a UART model answering the valid/busy handshake.
  initial begin
    txn_t       cur;
    txn_t       nxt;
    int         n;
    bit         abort;
    logic [3:0] nvec;
    abort = 1'b0;
    data_arr[0] = 8'h41;
    data_arr[1] = 8'h42;
    data_arr[2] = 8'h43;
    data_arr[3] = 8'h44;

    repeat (3) @(posedge clk_x4);
    #1;
    check("reset_outputs", 32'({o_req_ack, o_grant, o_uart_data, o_uart_valid, o_timeout}), 32'd0);
    rst_x = 1'b1;

    // UART busy in IDLE must hold off the grant.
    uart_busy = 1'b1;
    cur = plan(4'b1000, 1'b0, 2);
    sb_q.push_back(cur);
    req_valid = 4'b1000;
    repeat (4) begin
      @(posedge clk_x4); #1;
      check("busy_hold_no_grant", 32'({o_grant, o_uart_valid}), 32'd0);
    end
    uart_busy = 1'b0;

    for (int i = 0; i < N && !abort; i++) begin
      wait_valid(n);
      if (n < 0) begin
        check("grant_wait", 32'd0, 32'd1);
        abort = 1'b1;
      end else begin
        if (i == 0) check("grant_latency", 32'(n), 32'd1);
        if (i < N - 1) begin
          nvec = (i < 5) ? 4'b1111 : (i < 9) ? 4'b0101 : 4'($urandom_range(1, 15));
          for (int j = 0; j < 4; j++) begin
            if (nvec[j] && !req_valid[j]) data_arr[j] = 8'($urandom);
          end
          req_valid = nvec;
          nxt = plan(nvec, i >= 8, (i < 8) ? 2 : -1);
          sb_q.push_back(nxt);
        end else begin
          req_valid = 4'b0000;
        end
        handshake(cur);
        cur = nxt;
      end
    end

    if (!abort) begin
      repeat (3) @(posedge clk_x4);
      #1;
      cur = plan(4'b0010, 1'b0, 0);
      sb_q.push_back(cur);
      req_valid = 4'b0010;
      wait_valid(n);
      if (n < 0) begin
        check("grant_wait_pre_reset", 32'd0, 32'd1);
        abort = 1'b1;
      end else begin
        data_arr[2] = 8'h5a;
        req_valid = 4'b0110;
        uart_busy = 1'b1;
        @(posedge clk_x4); #1;
        @(posedge clk_x4); #1;
        #1;
        rst_x = 1'b0;
        uart_busy = 1'b0;
        #1;
        check("async_reset_outputs", 32'({o_req_ack, o_grant, o_uart_data, o_uart_valid, o_timeout}), 32'd0);
        sb_q.delete();
        ptr_m = 0;
        exp_sticky = 1'b0;
        repeat (2) @(posedge clk_x4);
        #1;
        rst_x = 1'b1;
        cur = plan(4'b0110, 1'b0, 1);
        sb_q.push_back(cur);
        wait_valid(n);
        if (n < 0) begin
          check("grant_wait_post_reset", 32'd0, 32'd1);
        end else begin
          check("post_reset_latency", 32'(n), 32'd1);
          req_valid = 4'b0000;
          handshake(cur);
        end
      end
    end

    repeat (6) @(posedge clk_x4);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
